// File: rtl/cic_pkg.sv
// +--------------------------------------------------------------------+
// | cic_pkg : shared widths, defaults and helpers for the CIC decimator |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package cic_pkg;

  localparam int MAX_STAGES    = 6;
  localparam int CIC_IN_WIDTH  = 7;
  localparam int CIC_OUT_WIDTH = 16;
  localparam int CIC_STAGES    = 3;
  localparam int CIC_DECIM     = 8;
  localparam int SAMPLE_CNT_W  = 16;

  // Element type written into CIC_data_transferFIFO.
  typedef logic [CIC_OUT_WIDTH-1:0] cic_sample_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Bit growth of an N-stage, M=1 CIC is N*log2(R).
  function automatic int acc_width(input int in_w, input int stages, input int decim);
    return in_w + stages * clog2(decim);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_comb_stage.sv
// +--------------------------------------------------------------------+
// | cic_comb_stage : one M=1 comb section, advancing on a valid token   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module cic_comb_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             vld_q;

  assign diff_d = data_i - dly_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dly_q  <= '0;
      diff_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        dly_q  <= data_i;
        diff_q <= diff_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign data_o = diff_q;

endmodule

`default_nettype wire

// File: rtl/cic_decimator.sv
// +--------------------------------------------------------------------+
// | cic_decimator : N-stage CIC decimator, one strobed output per R in  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_WIDTH  = CIC_IN_WIDTH,
  parameter int OUT_WIDTH = CIC_OUT_WIDTH,
  parameter int STAGES    = CIC_STAGES,
  parameter int DECIM     = CIC_DECIM
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [IN_WIDTH-1:0]     data_in,
  output logic [OUT_WIDTH-1:0]    data_out,
  output logic                    data_valid,
  output logic [SAMPLE_CNT_W-1:0] sample_cnt
);

  localparam int ACC_W = acc_width(IN_WIDTH, STAGES, DECIM);
  localparam int CNT_W = clog2(DECIM);

  logic [ACC_W-1:0]        integ_q [STAGES];
  logic [ACC_W-1:0]        integ_d [STAGES];
  logic [CNT_W-1:0]        dec_cnt_q;
  logic [CNT_W-1:0]        dec_cnt_d;
  logic                    strobe;
  logic [ACC_W-1:0]        dec_reg_q;
  logic                    dec_vld_q;

  logic [ACC_W-1:0]        comb_data [STAGES+1];
  logic                    comb_vld  [STAGES+1];

  logic [OUT_WIDTH-1:0]    out_d;
  logic [OUT_WIDTH-1:0]    data_out_q;
  logic                    data_valid_q;
  logic [SAMPLE_CNT_W-1:0] sample_cnt_q;

  // Each integrator adds the previous stage's pre-update value (registered chain).
  always_comb begin
    for (int k = 0; k < STAGES; k++) integ_d[k] = integ_q[k];
    if (enable) begin
      integ_d[0] = integ_q[0] + ACC_W'(data_in);
      for (int k = 1; k < STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // DECIM is a power of two, so the counter wraps naturally.
  assign dec_cnt_d = enable ? dec_cnt_q + 1'b1 : dec_cnt_q;
  assign strobe    = enable && (dec_cnt_q == CNT_W'(DECIM - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
      dec_cnt_q <= '0;
      dec_reg_q <= '0;
      dec_vld_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= integ_d[k];
      dec_cnt_q <= dec_cnt_d;
      dec_vld_q <= strobe;
      if (strobe) dec_reg_q <= integ_q[STAGES-1];
    end
  end

  assign comb_data[0] = dec_reg_q;
  assign comb_vld[0]  = dec_vld_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_comb
    cic_comb_stage #(
      .WIDTH (ACC_W)
    ) u_comb (
      .clock  (clock),
      .reset  (reset),
      .vld_i  (comb_vld[s]),
      .data_i (comb_data[s]),
      .vld_o  (comb_vld[s+1]),
      .data_o (comb_data[s+1])
    );
  end

  if (ACC_W >= OUT_WIDTH) begin : g_out_msb
    assign out_d = comb_data[STAGES][ACC_W-1 -: OUT_WIDTH];
  end else begin : g_out_zext
    assign out_d = OUT_WIDTH'(comb_data[STAGES]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      data_valid_q <= comb_vld[STAGES];
      if (comb_vld[STAGES]) begin
        data_out_q   <= out_d;
        sample_cnt_q <= sample_cnt_q + 1'b1;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sample_cnt = sample_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cic_decimator.sv
// +--------------------------------------------------------------------+
// | tb_cic_decimator : randomized bench against a closed-form CIC model |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_cic_decimator;

  localparam int IN_W  = 7;
  localparam int OUT_W = 16;
  localparam int N     = 3;
  localparam int R     = 8;
  localparam int ACC_W = IN_W + N * 3;
  localparam longint MASK = (64'd1 << ACC_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [IN_W-1:0]  data_in;
  logic [OUT_W-1:0] data_out;
  logic             data_valid;
  logic [15:0]      sample_cnt;

  cic_decimator #(
    .IN_WIDTH  (IN_W),
    .OUT_WIDTH (OUT_W),
    .STAGES    (N),
    .DECIM     (R)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sample_cnt (sample_cnt)
  );

  always #5 clock = ~clock;

  typedef struct { longint due; longint val; } exp_t;

  int      n_vec = 0;
  int      n_err = 0;
  longint  cyc   = 0;
  bit      armed = 1'b0;
  int      xs[$];
  longint  vs[$];
  exp_t    pend[$];
  longint  last_out;
  int      exp_cnt;
  longint  pv[$];
  longint  pt[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint binom(input longint n, input int k);
    longint c;
    if (n < k) return 0;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // N cascaded running sums seen before the t-th accepted sample.
  function automatic longint integ_at(input int t);
    longint acc;
    acc = 0;
    for (int j = 0; j < t; j++) acc += longint'(xs[j]) * binom(t - 1 - j, N - 1);
    return acc & MASK;
  endfunction

  // N-th backward difference of the decimated sequence, zero history.
  function automatic longint comb_out();
    longint acc;
    int     m;
    m   = vs.size() - 1;
    acc = 0;
    for (int k = 0; k <= N; k++) begin
      if (m - k >= 0) acc += ((k % 2 == 0) ? 1 : -1) * binom(N, k) * vs[m-k];
    end
    return (acc & MASK) >> (ACC_W - OUT_W);
  endfunction

  task automatic step(input bit rst, input bit en, input int din);
    bit ev;
    reset   = rst;
    enable  = en;
    data_in = IN_W'(din);
    if (rst) begin
      xs.delete(); vs.delete(); pend.delete();
      last_out = 0;
      exp_cnt  = 0;
      armed    = 1'b1;
    end else if (en) begin
      if (xs.size() % R == R - 1) begin
        vs.push_back(integ_at(xs.size()));
        pend.push_back('{cyc + 1 + 4, comb_out()});
      end
      xs.push_back(din);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (armed) begin
      ev = (pend.size() > 0) && (pend[0].due == cyc);
      chk("data_valid", data_valid, ev);
      if (ev) begin
        last_out = pend[0].val;
        void'(pend.pop_front());
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        pv.push_back(data_out);
        pt.push_back(cyc);
      end
      chk("data_out", data_out, last_out);
      chk("sample_cnt", sample_cnt, exp_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic check_train(input string tag, input int pulses, input int gap, input longint level);
    chk({tag, "_pulses"}, pv.size(), pulses);
    for (int i = 1; i < pv.size(); i++) chk({tag, "_gap"}, pt[i] - pt[i-1], gap);
    for (int i = 3; i < pv.size(); i++) chk({tag, "_level"}, pv[i], level);
  endtask

  initial begin
    longint sum;
    longint p8;
    int     nz;
    reset   = 1'b1;
    enable  = 1'b0;
    data_in = '0;
    @(negedge clock);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 127);

    pv.delete(); pt.delete();
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 23);
    idle(8);
    check_train("dc", 25, R, 23 * R * R * R);

    step(1'b1, 1'b0, 0);
    pv.delete(); pt.delete();
    for (int i = 0; i < 120; i++) step(1'b0, 1'b1, 127);
    idle(8);
    check_train("fullscale", 15, R, 65024);

    step(1'b1, 1'b0, 0);
    pv.delete(); pt.delete();
    step(1'b0, 1'b1, 1);
    for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 0);
    idle(8);
    sum = 0;
    nz  = 0;
    foreach (pv[i]) begin
      sum += pv[i];
      if (pv[i] != 0) nz++;
    end
    // Sampling every R-th point of the impulse response keeps R^(N-1) of its area.
    chk("impulse_sum", sum, R * R);
    chk("impulse_nz_le3", nz <= 3, 1);

    step(1'b1, 1'b0, 0);
    pv.delete(); pt.delete();
    for (int i = 0; i < 160; i++) step(1'b0, (i % 2) == 0, 1);
    idle(8);
    check_train("gated", 10, 2 * R, 512);

    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 2 * R; i++) step(1'b0, 1'b1, $urandom_range(0, 127));
    step(1'b0, 1'b1, 5);
    pv.delete(); pt.delete();
    step(1'b1, 1'b1, 5);
    for (int i = 0; i < R; i++) step(1'b0, 1'b1, $urandom_range(0, 127));
    p8 = cyc;
    idle(8);
    chk("midrst_pulses", pv.size(), 1);
    if (pt.size() > 0) chk("midrst_latency", pt[0] - p8, 4);
    chk("midrst_cnt", sample_cnt, 1);

    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 600; i++) step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 127));
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
